// File: rtl/key_sched_ctrl_pkg.sv
// Shared definitions for the AES-128 key-schedule controller.
// Holds the key/round-key dimensions, the controller state enum and the
// GF(2^8) helpers used to build the S-box combinationally.
package key_sched_ctrl_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_KEY_W = 128;
    localparam int unsigned RK_ADDR_W = 4;

    typedef enum logic [0:0] {
        IDLE,
        EXPAND
    } state_e;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, with 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        // Accumulates x^(2+4+...+128) = x^254.
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_sched_ctrl_ke_core.sv
// ke_core: one combinational AES-128 key-expansion round.
// Ports:
//   word_in  - previous round key {W0,W1,W2,W3}, W0 in bits [127:96]
//   i        - round number, 1-based (1 selects rcon 0x01)
//   word_out - next round key, same word order
module ke_core
    import key_sched_ctrl_pkg::*;
(
    input  logic [AES_KEY_W-1:0] word_in,
    input  logic [7:0]           i,
    output logic [AES_KEY_W-1:0] word_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon;

    always_comb begin
        case (i)
            8'd1:    rcon = 8'h01;
            8'd2:    rcon = 8'h02;
            8'd3:    rcon = 8'h04;
            8'd4:    rcon = 8'h08;
            8'd5:    rcon = 8'h10;
            8'd6:    rcon = 8'h20;
            8'd7:    rcon = 8'h40;
            8'd8:    rcon = 8'h80;
            8'd9:    rcon = 8'h1b;
            8'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        w0  = word_in[127:96];
        w1  = word_in[95:64];
        w2  = word_in[63:32];
        w3  = word_in[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t   = sub ^ {rcon, 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        word_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: expands one AES-128 cipher key into NR+1 round keys, one round
// per clock, and serves them from an internal register file.
// Ports:
//   clk, rst    - clock; synchronous active-high reset
//   start       - expand key_in (accepted only in IDLE)
//   key_in      - cipher key, W0 in bits [127:96]
//   busy        - expansion in progress
//   done        - one-cycle pulse after the last round key is written
//   keys_valid  - file holds the complete schedule of the last accepted key
//   rk_addr     - round-key read index
//   rk_data     - combinational read of rk[rk_addr]; 0 for indices above NR
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AES_KEY_W-1:0] key_in,
    output logic                 busy,
    output logic                 done,
    output logic                 keys_valid,
    input  logic [RK_ADDR_W-1:0] rk_addr,
    output logic [AES_KEY_W-1:0] rk_data
);

    state_e               state_q, state_d;
    logic [RK_ADDR_W-1:0] round_q, round_d;
    logic [AES_KEY_W-1:0] work_q, work_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 kv_q, kv_d;

    logic [AES_KEY_W-1:0] rk_q [NR+1];
    logic                 rk_we;
    logic [RK_ADDR_W-1:0] rk_wa;
    logic [AES_KEY_W-1:0] rk_wd;

    logic [AES_KEY_W-1:0] ke_out;

    ke_core u_ke_core (
        .word_in  (work_q),
        .i        ({4'b0000, round_q}),
        .word_out (ke_out)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        work_d  = work_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        rk_we   = 1'b0;
        rk_wa   = round_q;
        rk_wd   = ke_out;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rk_we   = 1'b1;
                    rk_wa   = '0;
                    rk_wd   = key_in;
                    work_d  = key_in;
                    round_d = 4'd1;
                    kv_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                rk_we  = 1'b1;
                work_d = ke_out;
                if (round_q == RK_ADDR_W'(NR)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    // Register file rather than a RAM: needs reset clearing and combinational read.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NR + 1; k++) begin
            if (rst) begin
                rk_q[k] <= '0;
            end else if (rk_we && (rk_wa == RK_ADDR_W'(k))) begin
                rk_q[k] <= rk_wd;
            end
        end
    end

    always_comb begin
        rk_data = '0;
        for (int unsigned k = 0; k < NR + 1; k++) begin
            if (rk_addr == RK_ADDR_W'(k)) begin
                rk_data = rk_q[k];
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;

endmodule
